// File: rtl/cmp_bht_pkg.sv
// Shared definitions for the branch comparator and its prediction table.
// Holds condition codes, 2-bit counter states and the saturating update rule.
// No logic of its own; imported by cmp_bht and bht_table.
package cmp_bht_pkg;

  // Branch condition codes carried in d_option
  typedef enum logic [2:0] {
    CMP_NEVER  = 3'b000,
    CMP_EQ     = 3'b001,
    CMP_NE     = 3'b010,
    CMP_LEZ    = 3'b011,
    CMP_GTZ    = 3'b100,
    CMP_LTZ    = 3'b101,
    CMP_GEZ    = 3'b110,
    CMP_ALWAYS = 3'b111
  } cmp_opt_e;

  // Two-bit saturating counter states; MSB is the taken prediction
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;
  localparam logic [1:0] CTR_RST = CTR_WNT;

  // Next counter value after a resolved branch, saturating at both ends
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != CTR_ST) begin
      nxt = ctr + 2'd1;
    end else if (!taken && ctr != CTR_SNT) begin
      nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cmp_bht_bht_table.sv
// PC-indexed table of 2-bit saturating counters with write-first read bypass.
// Read is combinational (zero cycles); training lands on the next rising edge.
// No backpressure: the caller gates training with wr_en.
module bht_table
  import cmp_bht_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int IDX_LSB = 2,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] rd_pc,
  output logic            rd_taken,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic            wr_taken
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]       r_ctr [DEPTH];
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic [1:0]       w_wr_next;
  logic             w_unused_pc;

  assign w_rd_idx  = rd_pc[IDX_LSB +: IDX_W];
  assign w_wr_idx  = wr_pc[IDX_LSB +: IDX_W];
  assign w_wr_next = ctr_next(r_ctr[w_wr_idx], wr_taken);

  // Only the index slice of each PC matters; aliasing is intentional
  assign w_unused_pc = ^{rd_pc, wr_pc};

  // A same-index update in flight is visible to the reader this cycle
  assign rd_taken = (wr_en && (w_rd_idx == w_wr_idx)) ? w_wr_next[1] : r_ctr[w_rd_idx][1];

  // Counter array: reset to weak not-taken, otherwise train the written entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= CTR_RST;
      end
    end else if (wr_en) begin
      r_ctr[w_wr_idx] <= w_wr_next;
    end
  end

endmodule

// File: rtl/cmp_bht.sv
// D-stage branch comparator with F-stage direction prediction and statistics.
// res/mispredict/f_pred_taken are combinational; table and counters update on the edge.
// Stall or bubble in D suppresses all state updates; outputs keep tracking inputs.
module cmp_bht
  import cmp_bht_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int IDX_LSB   = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          f_pc,
  output logic                 f_pred_taken,
  input  logic                 d_valid,
  input  logic                 d_stall,
  input  logic [31:0]          d_pc,
  input  logic [2:0]           d_option,
  input  logic [WIDTH-1:0]     input1,
  input  logic [WIDTH-1:0]     input2,
  input  logic                 d_pred_taken,
  output logic                 res,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  logic                 w_neg;
  logic                 w_zero;
  logic                 w_cond;
  logic                 w_commit;
  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_mispred_cnt;

  assign w_neg  = input1[WIDTH-1];
  assign w_zero = (input1 == '0);

  // Resolve the branch condition; every option drives res
  always_comb begin
    res = 1'b0;
    case (d_option)
      CMP_NEVER:  res = 1'b0;
      CMP_EQ:     res = (input1 == input2);
      CMP_NE:     res = (input1 != input2);
      CMP_LEZ:    res = w_neg | w_zero;
      CMP_GTZ:    res = ~w_neg & ~w_zero;
      CMP_LTZ:    res = w_neg;
      CMP_GEZ:    res = ~w_neg;
      CMP_ALWAYS: res = 1'b1;
      default:    res = 1'b0;
    endcase
  end

  // Only genuinely conditional branches are predicted, trained and counted
  assign w_cond     = (d_option != CMP_NEVER) && (d_option != CMP_ALWAYS);
  assign mispredict = d_valid & w_cond & (res ^ d_pred_taken);
  assign w_commit   = reset & d_valid & ~d_stall & w_cond;

  bht_table #(
    .DEPTH   (BHT_DEPTH),
    .IDX_LSB (IDX_LSB),
    .PC_W    (32)
  ) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_pc    (f_pc),
    .rd_taken (f_pred_taken),
    .wr_en    (w_commit),
    .wr_pc    (d_pc),
    .wr_taken (res)
  );

  // Saturating retire statistics; reset wins over a coincident commit
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_commit) begin
      if (r_branch_cnt != '1) begin
        r_branch_cnt <= r_branch_cnt + 1'b1;
      end
      if (mispredict && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule
